// File: rtl/mmu_job_arbiter.sv
// Arbitrates two host requester channels onto one 2x2 matrix-multiply engine:
// one job at a time, round-robin grant, operand streaming, result capture and drain.
module mmu_job_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_transpose,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_transpose,
  output logic       req1_ready,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_id,
  output logic       resp_last,
  output logic       resp_err,
  input  logic       resp_ready,
  output logic       eng_rst,
  output logic       eng_load_en,
  output logic [7:0] eng_data,
  output logic       eng_transpose,
  input  logic       eng_out_valid,
  input  logic [7:0] eng_out_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_WAIT_OUT,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            id_q, id_d;
  logic            err_q, err_d;
  logic            tr_q, tr_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      buf_q [8];
  logic [7:0]      buf_d [8];

  logic            sel_valid;
  logic [7:0]      sel_data;
  logic            sel_tr;

  always_comb begin
    sel_valid = id_q ? req1_valid     : req0_valid;
    sel_data  = id_q ? req1_data      : req0_data;
    sel_tr    = id_q ? req1_transpose : req0_transpose;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    err_d        = err_q;
    tr_d         = tr_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    buf_d        = buf_q;

    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    resp_valid    = 1'b0;
    resp_data     = '0;
    resp_id       = 1'b0;
    resp_last     = 1'b0;
    resp_err      = 1'b0;
    eng_rst       = 1'b0;
    eng_load_en   = 1'b0;
    eng_data      = '0;
    eng_transpose = tr_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          id_d    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        eng_rst = 1'b1;
        idx_d   = '0;
        err_d   = 1'b0;
        tr_d    = 1'b0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        req0_ready = ~id_q;
        req1_ready = id_q;
        if (sel_valid) begin
          eng_load_en = 1'b1;
          eng_data    = sel_data;
          idx_d       = idx_q + 3'd1;
          // First byte carries the transpose flag; bypass so the engine sees it with that strobe
          if (idx_q == 3'd0) begin
            tr_d          = sel_tr;
            eng_transpose = sel_tr;
          end
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            tmo_d   = '0;
            state_d = S_WAIT_OUT;
          end
        end
      end

      S_WAIT_OUT: begin
        if (eng_out_valid) begin
          buf_d[idx_q] = eng_out_data;
          idx_d        = idx_q + 3'd1;
          tmo_d        = '0;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT silent cycles: report an all-zero errored result instead of a partial one
          err_d = 1'b1;
          for (int unsigned i = 0; i < 8; i++) begin
            buf_d[i] = '0;
          end
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DRAIN: begin
        resp_valid = 1'b1;
        resp_data  = buf_q[idx_q];
        resp_id    = id_q;
        resp_err   = err_q;
        resp_last  = (idx_q == 3'd7);
        if (resp_ready) begin
          if (idx_q == 3'd7) begin
            idx_d        = '0;
            last_grant_d = id_q;
            state_d      = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      tr_q         <= 1'b0;
      idx_q        <= '0;
      tmo_q        <= '0;
      buf_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      err_q        <= err_d;
      tr_q         <= tr_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      buf_q        <= buf_d;
    end
  end

endmodule

// File: tb/tb_mmu_job_arbiter.sv
// Directed bench for mmu_job_arbiter: cycle-stepped host/engine models, immediate-assert checks.
module tb_mmu_job_arbiter;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned TW      = 7;

  localparam logic [63:0] OPS_A = 64'h0102_0304_0506_0708;
  localparam logic [63:0] RES_A = 64'h0013_0016_002B_0032;
  localparam logic [63:0] OPS_B = 64'h1112_1314_1516_1718;
  localparam logic [63:0] RES_B = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] RES_C = 64'h1122_3344_5566_7788;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_transpose, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_transpose, req1_ready;
  logic [7:0] req1_data;
  logic       resp_valid, resp_id, resp_last, resp_err, resp_ready;
  logic [7:0] resp_data;
  logic       eng_rst, eng_load_en, eng_transpose, eng_out_valid;
  logic [7:0] eng_data, eng_out_data;
  logic       busy;

  always #5 clk = ~clk;

  mmu_job_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_transpose(req0_transpose), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_transpose(req1_transpose), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id), .resp_last(resp_last),
    .resp_err(resp_err), .resp_ready(resp_ready),
    .eng_rst(eng_rst), .eng_load_en(eng_load_en), .eng_data(eng_data), .eng_transpose(eng_transpose),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // host channel models
  int          ch_act [2];
  int          ch_idx [2];
  int          ch_jobs [2];
  logic [63:0] ch_bytes [2];
  logic        ch_tr [2];
  logic        ch_toggle [2];
  logic        ch_phase [2];
  int          owner;
  logic        own_tr;

  // response capture
  int          rcnt;
  logic [63:0] rbuf;
  logic [7:0]  rlast, rerr;
  int          ndone;
  logic [63:0] jdata [16];
  logic        jid [16];
  logic [7:0]  jerr [16];
  logic [7:0]  jlast [16];
  int          stall_byte, stall_left, stall_seen, hold_viol;
  logic [7:0]  hold_val;

  // monitors
  int          ready_viol, load_viol, tr_viol, rstpulses, ld_n, wc, gap;
  logic        warm;
  logic [63:0] ld_log;

  // engine model
  int          e_state, e_loads, e_wait, e_oidx, e_delay;
  logic        e_silent;
  logic [63:0] e_resp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ld_n = 0; ld_log = '0; rstpulses = 0; load_viol = 0; ready_viol = 0; tr_viol = 0;
    hold_viol = 0; stall_seen = 0; gap = -1; warm = 1'b0; wc = 0;
  endtask

  task automatic clear_tracking();
    for (int c = 0; c < 2; c++) begin
      ch_act[c] = 0; ch_idx[c] = 0; ch_jobs[c] = 0; ch_bytes[c] = '0;
      ch_tr[c] = 1'b0; ch_toggle[c] = 1'b0; ch_phase[c] = 1'b0;
    end
    owner = -1; own_tr = 1'b0; rcnt = 0; rbuf = '0; rlast = '0; rerr = '0;
    stall_byte = -1; stall_left = 0;
    e_state = 0; e_loads = 0; e_wait = 0; e_oidx = 0;
  endtask

  task automatic start_job(input int c, input logic [63:0] ops, input logic tr, input logic tog, input int n);
    ch_bytes[c] = ops; ch_tr[c] = tr; ch_toggle[c] = tog; ch_phase[c] = 1'b0;
    ch_idx[c] = 0; ch_jobs[c] = n; ch_act[c] = 1;
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update all models.
  task automatic step();
    logic       v [2];
    logic [7:0] b [2];
    logic       acc0, acc1, exp_load;
    logic [7:0] exp_data;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      v[c] = (ch_act[c] != 0) && !(ch_toggle[c] && ch_phase[c]);
      b[c] = ch_bytes[c][63 - 8*ch_idx[c] -: 8];
      ch_phase[c] = ~ch_phase[c];
    end
    req0_valid = v[0]; req0_data = b[0]; req0_transpose = ch_tr[0];
    req1_valid = v[1]; req1_data = b[1]; req1_transpose = ch_tr[1];
    resp_ready = !(rcnt == stall_byte && stall_left > 0);
    eng_out_valid = (e_state == 2);
    eng_out_data  = (e_state == 2) ? e_resp[63 - 8*e_oidx -: 8] : 8'h00;
    #1;
    if ((!busy || eng_rst) && (req0_ready || req1_ready)) ready_viol++;
    if (req0_ready && req1_ready) ready_viol++;
    if (owner == 0 && req1_ready) ready_viol++;
    if (owner == 1 && req0_ready) ready_viol++;

    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    exp_load = acc0 || acc1;
    exp_data = acc0 ? b[0] : (acc1 ? b[1] : 8'h00);
    if (eng_load_en !== exp_load) load_viol++;
    if (exp_load && eng_data !== exp_data) load_viol++;
    if (eng_load_en) begin
      ld_log = {ld_log[55:0], eng_data};
      ld_n++;
    end
    for (int c = 0; c < 2; c++) begin
      if ((c == 0 && acc0) || (c == 1 && acc1)) begin
        if (owner < 0) begin
          owner = c; own_tr = ch_tr[c];
        end
        ch_idx[c]++;
        if (ch_idx[c] == 8) begin
          ch_idx[c] = 0;
          ch_jobs[c]--;
          if (ch_jobs[c] == 0) ch_act[c] = 0;
        end
      end
    end
    if (owner >= 0 && eng_transpose !== own_tr) tr_viol++;

    if (resp_valid) begin
      if (resp_ready) begin
        rbuf  = {rbuf[55:0], resp_data};
        rlast = {rlast[6:0], resp_last};
        rerr  = {rerr[6:0], resp_err};
        rcnt++;
        if (rcnt == 8) begin
          jdata[ndone] = rbuf; jid[ndone] = resp_id; jerr[ndone] = rerr; jlast[ndone] = rlast;
          ndone++;
          rcnt = 0;
        end
      end else begin
        if (stall_seen == 0) hold_val = resp_data;
        else if (resp_data !== hold_val) hold_viol++;
        stall_seen++;
        stall_left--;
      end
    end

    if (eng_load_en) begin
      warm = 1'b1; wc = 0;
    end else if (warm) begin
      if (resp_valid) begin
        gap = wc; warm = 1'b0;
      end else begin
        wc++;
      end
    end

    if (eng_rst) begin
      rstpulses++;
      owner   = -1;
      e_state = 0;
      e_loads = 0;
    end else if (eng_load_en) begin
      e_loads++;
      if (e_loads == 8 && !e_silent) begin
        e_oidx  = 0;
        e_wait  = e_delay;
        e_state = (e_delay == 0) ? 2 : 1;
      end
    end else if (e_state == 1) begin
      e_wait--;
      if (e_wait == 0) e_state = 2;
    end else if (e_state == 2) begin
      e_oidx++;
      if (e_oidx == 8) e_state = 0;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (ndone < target && n < budget) begin
      step();
      n++;
    end
    check(tag, (ndone >= target), 1'b1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_transpose = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_transpose = 1'b0;
    resp_ready = 1'b0; eng_out_valid = 1'b0; eng_out_data = '0;
    clear_tracking();
    ndone = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    e_delay = 3; e_silent = 1'b0; e_resp = RES_A;
    clear_logs();
    reset_dut();

    // reset state
    check("rst_ctrl", {busy, req0_ready, req1_ready, resp_valid, resp_id, resp_last, resp_err,
                       eng_rst, eng_load_en, eng_transpose}, '0);
    check("rst_data", {resp_data, eng_data}, '0);

    // single job on channel 0
    clear_logs();
    e_resp = RES_A;
    start_job(0, OPS_A, 1'b0, 1'b0, 1);
    wait_done(1, 300, "t1_done");
    check("t1_rst_pulses", rstpulses, 1);
    check("t1_load_count", ld_n, 8);
    check("t1_load_bytes", ld_log, OPS_A);
    check("t1_resp_data", jdata[0], RES_A);
    check("t1_resp_id", jid[0], 1'b0);
    check("t1_resp_last", jlast[0], 8'h01);
    check("t1_resp_err", jerr[0], 8'h00);
    check("t1_gap", gap, 11);
    check("t1_viol", {ready_viol[15:0], load_viol[15:0], tr_viol[15:0]}, '0);

    // fairness: both channels requesting continuously from reset
    reset_dut();
    clear_logs();
    start_job(0, OPS_A, 1'b0, 1'b0, 2);
    start_job(1, OPS_B, 1'b0, 1'b0, 2);
    wait_done(4, 800, "fair_done");
    check("fair_order", {jid[0], jid[1], jid[2], jid[3]}, 4'b0101);
    check("fair_ready_viol", ready_viol, 0);
    check("fair_rst_pulses", rstpulses, 4);
    check("fair_loads", {ld_n[15:0], load_viol[15:0]}, {16'd32, 16'd0});
    check("fair_data1", jdata[1], RES_A);

    // channel 1, bubbles every other cycle, transpose set
    clear_logs();
    e_resp = RES_B;
    start_job(1, OPS_B, 1'b1, 1'b1, 1);
    wait_done(5, 300, "t3_done");
    check("t3_load_count", ld_n, 8);
    check("t3_load_bytes", ld_log, OPS_B);
    check("t3_viol", {load_viol[15:0], tr_viol[15:0]}, '0);
    check("t3_tr_held", eng_transpose, 1'b1);
    check("t3_resp", {jdata[4], 7'd0, jid[4]}, {RES_B, 8'h01});

    // backpressure on the third result byte; transpose must drop at the new grant
    clear_logs();
    e_resp = RES_C;
    stall_byte = 2; stall_left = 5;
    start_job(0, OPS_A, 1'b0, 1'b0, 1);
    wait_done(6, 300, "t4_done");
    stall_byte = -1;
    check("t4_resp_data", jdata[5], RES_C);
    check("t4_stall_cycles", stall_seen, 5);
    check("t4_hold_val", hold_val, 8'h33);
    check("t4_hold_viol", hold_viol, 0);
    check("t4_last", jlast[5], 8'h01);
    check("t4_tr_viol", tr_viol, 0);

    // engine silent: timeout yields an errored all-zero response
    clear_logs();
    e_silent = 1'b1;
    start_job(0, OPS_A, 1'b0, 1'b0, 1);
    wait_done(7, 400, "t5_done");
    check("t5_resp_data", jdata[6], 64'h0);
    check("t5_resp_err", jerr[6], 8'hFF);
    check("t5_last_id", {jlast[6], 7'd0, jid[6]}, {8'h01, 8'h00});
    check("t5_gap", gap, TIMEOUT);

    // following job is unaffected
    clear_logs();
    e_silent = 1'b0;
    e_resp = RES_A;
    start_job(1, OPS_B, 1'b0, 1'b0, 1);
    wait_done(8, 300, "t6_done");
    check("t6_resp", {jdata[7], jerr[7], 7'd0, jid[7]}, {RES_A, 8'h00, 8'h01});

    // reset during LOAD after 4 accepted bytes
    clear_logs();
    start_job(0, OPS_A, 1'b0, 1'b0, 1);
    for (int n = 0; n < 50 && ch_idx[0] < 4; n++) step();
    check("t7_reached4", ch_idx[0], 4);
    ch_act[0] = 0;
    step();
    check("t7_midjob_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t7_rst_ctrl", {busy, req0_ready, req1_ready, resp_valid, resp_id, resp_last, resp_err,
                          eng_rst, eng_load_en, eng_transpose}, '0);
    check("t7_rst_data", {resp_data, eng_data}, '0);
    rst = 1'b0;
    owner = -1; rcnt = 0;
    repeat (5) step();
    check("t7_no_resp", {ndone[15:0], rcnt[15:0]}, {16'd8, 16'd0});
    check("t7_idle", busy, 1'b0);

    clear_logs();
    e_resp = RES_A;
    start_job(0, OPS_A, 1'b0, 1'b0, 1);
    wait_done(9, 300, "t8_done");
    check("t8_load_bytes", ld_log, OPS_A);
    check("t8_resp", {jdata[8], jerr[8], 7'd0, jid[8]}, {RES_A, 8'h00, 8'h00});
    check("t8_viol", {ready_viol[15:0], load_viol[15:0], rstpulses[15:0]}, {16'd0, 16'd0, 16'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
